j1_io_bank: RTL and testbench

//  Parametrised memory-mapped I/O bank for the J1 I/O bus: replaces the hand-written LED/HEX/KEY/SW decode in FPGA tops.
//  N_OUT write/readback output registers; N_IN input channels, each with a synchroniser, debouncer and sticky edge-event register.

---
 rtl/j1_io_pkg.sv | 14 +
 rtl/io_debounce.sv | 50 +++++
 rtl/j1_io_bank.sv | 107 ++++++++++
 tb/tb_j1_io_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_io_pkg.sv
// rtl/j1_io_pkg.sv - shared register-map constants and word type for the J1 I/O bank
package j1_io_pkg;

  typedef logic [15:0] io_word_t;

  // Per-channel register offsets within a channel's window
  localparam io_word_t OFS_DATA    = 16'h0000;
  localparam io_word_t OFS_EVENT   = 16'h0002;
  localparam io_word_t OFS_ENABLE  = 16'h0004;

  localparam io_word_t CH_BASE_OFS = 16'h0020;
  localparam io_word_t CH_STRIDE   = 16'h0008;

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - per-channel synchroniser and counter debouncer with change mask
module io_debounce #(
  parameter int DW              = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] raw,
  output logic [DW-1:0] deb,
  output logic [DW-1:0] chg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] sync_ff [SYNC_STAGES];
  logic [DW-1:0] sync;
  logic [DW-1:0] deb_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign sync = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_ff[k] <= '0;
      deb <= '0;
      cnt <= '0;
    end else begin
      sync_ff[0] <= raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_ff[k] <= sync_ff[k-1];
      deb <= deb_next;
      cnt <= cnt_next;
    end
  end

  // Any return to the debounced value clears the count; a different non-equal
  // value keeps counting and the latest synchronised word is what gets captured.
  always_comb begin
    deb_next = deb;
    cnt_next = '0;
    if (sync != deb) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) deb_next = sync;
      else                                  cnt_next = cnt + CW'(1);
    end
  end

  assign chg = deb_next ^ deb;

endmodule

// File: rtl/j1_io_bank.sv
// rtl/j1_io_bank.sv - memory-mapped output registers, debounced inputs, sticky events and irq
module j1_io_bank
  import j1_io_pkg::*;
#(
  parameter logic [15:0]      BASE_ADDR       = 16'h4000,
  parameter int               DW              = 16,
  parameter int               N_OUT           = 6,
  parameter int               N_IN            = 2,
  parameter logic [N_OUT-1:0] OUT_INV_MASK    = 6'b111100,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 240000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         io_addr,
  input  logic [DW-1:0]       io_dout,
  input  logic                io_wr,
  input  logic                io_rd,
  output logic [DW-1:0]       io_din,
  output logic [N_OUT*DW-1:0] out_q,
  input  logic [N_IN*DW-1:0]  in_raw,
  output logic                irq
);

  logic [DW-1:0]    deb_w    [N_IN];
  logic [DW-1:0]    chg_w    [N_IN];
  logic [DW-1:0]    event_q  [N_IN];
  logic [DW-1:0]    enable_q [N_IN];
  logic [N_OUT-1:0] out_hit;
  logic [N_IN-1:0]  data_hit;
  logic [N_IN-1:0]  event_hit;
  logic [N_IN-1:0]  enable_hit;
  logic             irq_next;

  function automatic io_word_t chan_addr(input int j, input io_word_t ofs);
    return BASE_ADDR + CH_BASE_OFS + io_word_t'(j * CH_STRIDE) + ofs;
  endfunction

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    io_debounce #(
      .DW              (DW),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (in_raw[g*DW +: DW]),
      .deb   (deb_w[g]),
      .chg   (chg_w[g])
    );
  end

  // Odd addresses never hit anything, even if BASE_ADDR itself were odd
  always_comb begin
    out_hit    = '0;
    data_hit   = '0;
    event_hit  = '0;
    enable_hit = '0;
    for (int i = 0; i < N_OUT; i++)
      out_hit[i] = !io_addr[0] && (io_addr == BASE_ADDR + io_word_t'(2 * i));
    for (int j = 0; j < N_IN; j++) begin
      data_hit[j]   = !io_addr[0] && (io_addr == chan_addr(j, OFS_DATA));
      event_hit[j]  = !io_addr[0] && (io_addr == chan_addr(j, OFS_EVENT));
      enable_hit[j] = !io_addr[0] && (io_addr == chan_addr(j, OFS_ENABLE));
    end
  end

  always_comb begin
    irq_next = 1'b0;
    for (int j = 0; j < N_IN; j++) irq_next = irq_next | (|(event_q[j] & enable_q[j]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) out_q[i*DW +: DW] <= {DW{OUT_INV_MASK[i]}};
      for (int j = 0; j < N_IN; j++) begin
        event_q[j]  <= '0;
        enable_q[j] <= '0;
      end
      irq <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (io_wr && out_hit[i])
          out_q[i*DW +: DW] <= OUT_INV_MASK[i] ? ~io_dout : io_dout;
      // A change landing in the read-clear cycle survives the clear
      for (int j = 0; j < N_IN; j++) begin
        event_q[j] <= ((io_rd && event_hit[j]) ? '0 : event_q[j]) | chg_w[j];
        if (io_wr && enable_hit[j]) enable_q[j] <= io_dout;
      end
      irq <= irq_next;
    end
  end

  always_comb begin
    io_din = '0;
    if (io_rd) begin
      for (int i = 0; i < N_OUT; i++)
        if (out_hit[i]) io_din = out_q[i*DW +: DW] ^ {DW{OUT_INV_MASK[i]}};
      for (int j = 0; j < N_IN; j++) begin
        if (data_hit[j])   io_din = deb_w[j];
        if (event_hit[j])  io_din = event_q[j];
        if (enable_hit[j]) io_din = enable_q[j];
      end
    end
  end

endmodule

// File: tb/tb_j1_io_bank.sv
// tb/tb_j1_io_bank.sv - randomized and directed checks of j1_io_bank against a behavioural model
module tb_j1_io_bank;

  localparam int          DC   = 8;
  localparam int          SS   = 2;
  localparam logic [15:0] BASE = 16'h4000;
  localparam logic [5:0]  INV  = 6'b111100;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic        io_wr;
  logic        io_rd;
  logic [15:0] io_din;
  logic [95:0] out_q;
  logic [31:0] in_raw;
  logic        irq;

  j1_io_bank #(
    .BASE_ADDR       (BASE),
    .DW              (16),
    .N_OUT           (6),
    .N_IN            (2),
    .OUT_INV_MASK    (INV),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_din  (io_din),
    .out_q   (out_q),
    .in_raw  (in_raw),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model keeps output registers as the logical (un-inverted) values written
  logic [15:0] m_out [6];
  logic [15:0] m_deb [2];
  logic [15:0] m_evt [2];
  logic [15:0] m_en  [2];
  logic [15:0] m_syncq [2][$];
  int          m_run [2];
  logic        m_irq;

  logic [15:0] last_din;
  logic [31:0] raw_v;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m_out[i] = '0;
    for (int j = 0; j < 2; j++) begin
      m_deb[j] = '0;
      m_evt[j] = '0;
      m_en[j]  = '0;
      m_run[j] = 0;
      m_syncq[j] = {};
      for (int k = 0; k < SS; k++) m_syncq[j].push_back(16'h0000);
    end
    m_irq = 1'b0;
  endfunction

  function automatic logic [15:0] ch_addr(input int j, input int ofs);
    return BASE + 16'h0020 + 16'(8 * j + ofs);
  endfunction

  function automatic logic [95:0] model_out_q();
    logic [95:0] v;
    for (int i = 0; i < 6; i++) v[i*16 +: 16] = INV[i] ? ~m_out[i] : m_out[i];
    return v;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a, input logic rd);
    if (!rd) return 16'h0000;
    for (int i = 0; i < 6; i++) if (a == BASE + 16'(2 * i)) return m_out[i];
    for (int j = 0; j < 2; j++) begin
      if (a == ch_addr(j, 0)) return m_deb[j];
      if (a == ch_addr(j, 2)) return m_evt[j];
      if (a == ch_addr(j, 4)) return m_en[j];
    end
    return 16'h0000;
  endfunction

  function automatic void model_step(input logic r, input logic [15:0] a, input logic [15:0] d,
                                     input logic w, input logic rd, input logic [31:0] raw);
    logic        irq_n;
    logic [15:0] s;
    logic [15:0] chg;
    if (r) begin
      model_reset();
      return;
    end
    irq_n = 1'b0;
    for (int j = 0; j < 2; j++) irq_n = irq_n | (|(m_evt[j] & m_en[j]));
    if (w) begin
      for (int i = 0; i < 6; i++) if (a == BASE + 16'(2 * i)) m_out[i] = d;
      for (int j = 0; j < 2; j++) if (a == ch_addr(j, 4)) m_en[j] = d;
    end
    for (int j = 0; j < 2; j++) begin
      // Input reaches the debouncer SS cycles late; it must differ for DC samples in a row
      s = m_syncq[j].pop_front();
      m_syncq[j].push_back(raw[j*16 +: 16]);
      chg = '0;
      if (s == m_deb[j]) m_run[j] = 0;
      else begin
        m_run[j]++;
        if (m_run[j] == DC) begin
          chg      = s ^ m_deb[j];
          m_deb[j] = s;
          m_run[j] = 0;
        end
      end
      m_evt[j] = ((rd && a == ch_addr(j, 2)) ? 16'h0000 : m_evt[j]) | chg;
    end
    m_irq = irq_n;
  endfunction

  task automatic drive_cycle(input logic r, input logic [15:0] a, input logic [15:0] d,
                             input logic w, input logic rd);
    check("out_q", out_q, model_out_q());
    check("irq", irq, m_irq);
    reset   = r;
    io_addr = a;
    io_dout = d;
    io_wr   = w;
    io_rd   = rd;
    in_raw  = raw_v;
    #1;
    last_din = io_din;
    check("io_din", io_din, model_read(a, rd));
    model_step(r, a, d, w, rd, raw_v);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic rd_cycle(input logic [15:0] a);
    drive_cycle(1'b0, a, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic wr_cycle(input logic [15:0] a, input logic [15:0] d);
    drive_cycle(1'b0, a, d, 1'b1, 1'b0);
  endtask

  logic [15:0] addr_tab [14];
  int first;

  initial begin
    addr_tab = '{16'h4000, 16'h4002, 16'h4004, 16'h4006, 16'h4008, 16'h400A, 16'h4020,
                 16'h4022, 16'h4024, 16'h4028, 16'h402A, 16'h402C, 16'h4001, 16'h4030};
    reset = 1'b1; io_addr = '0; io_dout = '0; io_wr = 1'b0; io_rd = 1'b0;
    raw_v = '0; in_raw = '0;
    model_reset();
    repeat (2) @(negedge clk);

    check("rst_out_lo", out_q[31:0], 32'h0000_0000);
    check("rst_out_hi", out_q[95:32], {64{1'b1}});
    check("rst_irq", irq, 1'b0);
    foreach (addr_tab[k]) begin
      rd_cycle(addr_tab[k]);
      check("rst_read", last_din, 16'h0000);
    end

    wr_cycle(16'h4004, 16'h0079);
    check("wr_reg2", out_q[47:32], 16'hFF86);
    rd_cycle(16'h4004);
    check("rb_reg2", last_din, 16'h0079);
    wr_cycle(16'h4001, 16'h1234);
    check("odd_wr", out_q, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFF86, 16'h0000, 16'h0000});
    wr_cycle(16'h4024, 16'h0001);

    raw_v = 32'h0000_0001;
    idle(5);
    raw_v = 32'h0000_0000;
    idle(12);
    rd_cycle(16'h4020);
    check("glitch_data", last_din, 16'h0000);
    rd_cycle(16'h4022);
    check("glitch_event", last_din, 16'h0000);

    raw_v = 32'h0000_0001;
    first = -1;
    for (int k = 0; k < 30; k++) begin
      rd_cycle(16'h4020);
      if (first < 0 && last_din == 16'h0001) first = k;
    end
    check("deb_latency", first, SS + DC);
    check("irq_up", irq, 1'b1);

    rd_cycle(16'h4022);
    check("evt_read", last_din, 16'h0001);
    rd_cycle(16'h4022);
    check("evt_clear", last_din, 16'h0000);
    idle(1);
    check("irq_down", irq, 1'b0);

    raw_v = 32'h0000_0003;
    idle(SS + DC - 1);
    rd_cycle(16'h4022);
    check("evt_race_rd", last_din, 16'h0000);
    rd_cycle(16'h4022);
    check("evt_race_kept", last_din, 16'h0002);

    raw_v = 32'h0010_0003;
    idle(SS + 4);
    drive_cycle(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rd_cycle(16'h402A);
    check("rst_mid_evt", last_din, 16'h0000);
    first = -1;
    for (int k = 1; k < 30; k++) begin
      rd_cycle(16'h4028);
      if (k == 1) check("rst_mid_data", last_din, 16'h0000);
      if (first < 0 && last_din == 16'h0010) first = k;
    end
    check("requal_latency", first, SS + DC);

    for (int n = 0; n < 4000; n++) begin
      int op;
      logic [15:0] a;
      if ($urandom_range(0, 11) == 0) begin
        int ch = $urandom_range(0, 1);
        raw_v[ch*16 +: 16] = raw_v[ch*16 +: 16] ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      end
      a  = addr_tab[$urandom_range(0, 13)];
      op = $urandom_range(0, 99);
      if (op < 1)       drive_cycle(1'b1, a, 16'($urandom), 1'b0, 1'b0);
      else if (op < 30) drive_cycle(1'b0, a, 16'($urandom), 1'b1, 1'b0);
      else if (op < 70) drive_cycle(1'b0, a, 16'h0000, 1'b0, 1'b1);
      else              drive_cycle(1'b0, a, 16'h0000, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
